zigzag_reorder_buffer: RTL

//  Streaming ping-pong reorder buffer for 8x8 coefficient blocks. Accepts 64 samples per block
//  on a valid/ready input and emits them on a valid/ready output in a different order:
//  - INVERSE=0: row-major in, zig-zag out (quantiser -> entropy coder).
//  - INVERSE=1: zig-zag in, row-major out (decoder path).
//  Two 64-entry banks let one block fill while the other drains, giving sustained 1 sample/cycle.

---
 rtl/zigzag_reorder_buffer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/zigzag_reorder_buffer.sv
// Ping-pong 8x8 block reorder buffer: row-major <-> zig-zag, one sample per cycle sustained.
// Two 64-entry banks; a RAM read stage feeds a held output register.
module zigzag_reorder_buffer #(
  parameter int DATA_WIDTH = 11,
  parameter bit INVERSE    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [5:0]            out_index,
  output logic                  out_last
);

  // Packed table: entry p (6 bits) is the row-major index of zig-zag position p.
  function automatic logic [383:0] build_zz2rm();
    logic [383:0] tab;
    int idx;
    int lo;
    int hi;
    tab = '0;
    idx = 0;
    for (int d = 0; d < 15; d++) begin
      lo = (d > 7) ? d - 7 : 0;
      hi = (d < 7) ? d : 7;
      if ((d % 2) == 1) begin
        for (int r = lo; r <= hi; r++) begin
          tab[idx*6 +: 6] = 6'(8 * r + d - r);
          idx++;
        end
      end else begin
        for (int r = hi; r >= lo; r--) begin
          tab[idx*6 +: 6] = 6'(8 * r + d - r);
          idx++;
        end
      end
    end
    return tab;
  endfunction

  function automatic logic [383:0] build_rm2zz();
    logic [383:0] fwd;
    logic [383:0] inv;
    fwd = build_zz2rm();
    inv = '0;
    for (int p = 0; p < 64; p++) begin
      inv[int'(fwd[p*6 +: 6])*6 +: 6] = 6'(p);
    end
    return inv;
  endfunction

  localparam logic [383:0] ZZ2RM = build_zz2rm();
  localparam logic [383:0] RM2ZZ = build_rm2zz();

  // Writes scatter into the bank so that the drain side always reads addresses 0..63 in order.
  logic [5:0] wr_map [64];
  for (genvar i = 0; i < 64; i++) begin : g_map
    assign wr_map[i] = INVERSE ? ZZ2RM[i*6 +: 6] : RM2ZZ[i*6 +: 6];
  end

  logic [DATA_WIDTH-1:0] mem [128];

  logic [5:0]            wcnt_q, wcnt_d;
  logic                  wb_q, wb_d;
  logic [1:0]            full_q, full_d;
  logic [5:0]            rcnt_q, rcnt_d;
  logic                  rb_q, rb_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [5:0]            rd_index_q, rd_index_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [5:0]            out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;

  logic wr_en;
  logic issue;
  logic advance;

  always_comb begin
    wcnt_d      = wcnt_q;
    wb_d        = wb_q;
    full_d      = full_q;
    rcnt_d      = rcnt_q;
    rb_d        = rb_q;
    rd_valid_d  = rd_valid_q;
    rd_index_d  = rd_index_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;

    in_ready = !full_q[wb_q];
    wr_en    = in_valid && in_ready;
    advance  = rd_valid_q && (!out_valid_q || out_ready);
    // A read may issue only when the read stage is empty or moving on this edge.
    issue    = full_q[rb_q] && (!rd_valid_q || advance);
    rd_data_d = issue ? mem[{rb_q, rcnt_q}] : rd_data_q;

    if (wr_en) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        full_d[wb_q] = 1'b1;
        wb_d         = !wb_q;
      end
    end

    if (issue) begin
      rcnt_d     = rcnt_q + 6'd1;
      rd_index_d = rcnt_q;
      if (rcnt_q == 6'd63) begin
        full_d[rb_q] = 1'b0;
        rb_d         = !rb_q;
      end
    end

    if (issue) begin
      rd_valid_d = 1'b1;
    end else if (advance) begin
      rd_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data_q;
      out_index_d = rd_index_q;
      out_last_d  = (rd_index_q == 6'd63);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      wcnt_d      = '0;
      wb_d        = 1'b0;
      full_d      = 2'b00;
      rcnt_d      = '0;
      rb_d        = 1'b0;
      rd_valid_d  = 1'b0;
      rd_index_d  = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_index_d = '0;
      out_last_d  = 1'b0;
    end
  end

  // Bank storage and its read register are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[{wb_q, wr_map[wcnt_q]}] <= in_data;
    end
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q      <= '0;
      wb_q        <= 1'b0;
      full_q      <= 2'b00;
      rcnt_q      <= '0;
      rb_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_index_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      wb_q        <= wb_d;
      full_q      <= full_d;
      rcnt_q      <= rcnt_d;
      rb_q        <= rb_d;
      rd_valid_q  <= rd_valid_d;
      rd_index_q  <= rd_index_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule
